// File: rtl/delta_decompressor.sv
// delta_decompressor
// Rebuilds the original N-lane vector stream from tracebuffer entries.
// Uncompressed entries pass through and become the new reference vector.
// Compressed entries carry DELTA_SLOTS signed deltas per lane, MSB slot first.
// Each delta is subtracted from the running reference, one output per cycle.
// The packed vectors keep lane l in bits [l*DATA_WIDTH +: DATA_WIDTH].
module delta_decompressor #(
  parameter int   N           = 8,
  parameter int   DATA_WIDTH  = 32,
  parameter int   DELTA_SLOTS = 4,
  parameter logic COMPRESSED  = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    restart,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N*DATA_WIDTH-1:0] in_vector,
  input  logic                    in_comp,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [N*DATA_WIDTH-1:0] out_vector,
  output logic                    err_no_base,
  output logic [31:0]             vec_count
);

  localparam int PRECISION = DATA_WIDTH / DELTA_SLOTS;
  localparam int VW        = N * DATA_WIDTH;
  localparam int SW        = (DELTA_SLOTS > 1) ? $clog2(DELTA_SLOTS) : 1;
  localparam logic [PRECISION-1:0] INV = {1'b1, {(PRECISION-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    UNPACK,
    EMIT
  } state_t;

  state_t          state_q, state_d;
  logic            out_valid_q, out_valid_d;
  logic [VW-1:0]   out_vector_q, out_vector_d;
  logic [VW-1:0]   ref_q, ref_d;
  logic            ref_valid_q, ref_valid_d;
  logic [VW-1:0]   entry_q, entry_d;
  logic [SW-1:0]   slot_q, slot_d;
  logic            err_q, err_d;
  logic [31:0]     cnt_q, cnt_d;

  logic            out_free;
  logic            handoff;
  logic            accept;
  logic [VW-1:0]   unpack_src;
  int              unpack_slot;
  logic [VW-1:0]   unpack_vec;
  logic            cur_empty;
  logic            next_empty;

  // Slot s of a lane word sits s slots below the MSB end.
  function automatic logic [PRECISION-1:0] slot_bits(input logic [DATA_WIDTH-1:0] word,
                                                     input int s);
    logic [DATA_WIDTH-1:0] shifted;
    shifted = word >> ((DELTA_SLOTS - 1 - s) * PRECISION);
    return shifted[PRECISION-1:0];
  endfunction

  // Emptiness is decided by lane 0 alone; slots past the last one count as empty.
  function automatic logic slot_empty(input logic [VW-1:0] vec, input int s);
    if (s >= DELTA_SLOTS) return 1'b1;
    return slot_bits(vec[DATA_WIDTH-1:0], s) == INV;
  endfunction

  // Subtract the sign-extended slot-s delta from every lane of the base vector.
  function automatic logic [VW-1:0] apply_slot(input logic [VW-1:0] base,
                                               input logic [VW-1:0] entry,
                                               input int s);
    logic [VW-1:0]         res;
    logic [PRECISION-1:0]  d;
    logic [DATA_WIDTH-1:0] ext;
    res = '0;
    for (int l = 0; l < N; l++) begin
      d   = slot_bits(entry[l*DATA_WIDTH +: DATA_WIDTH], s);
      ext = {{(DATA_WIDTH-PRECISION){d[PRECISION-1]}}, d};
      res[l*DATA_WIDTH +: DATA_WIDTH] = base[l*DATA_WIDTH +: DATA_WIDTH] - ext;
    end
    return res;
  endfunction

  assign out_free = !out_valid_q || out_ready;
  assign handoff  = out_valid_q && out_ready;
  assign in_ready = rst_n && !restart && (state_q == IDLE) && out_free;
  assign accept   = in_valid && in_ready;

  // Slot 0 is unpacked straight from the input on acceptance so the first result
  // appears one cycle later; later slots come from the latched entry.
  always_comb begin
    unpack_src  = entry_q;
    unpack_slot = int'(slot_q);
    if (state_q == IDLE) begin
      unpack_src  = in_vector;
      unpack_slot = 0;
    end
  end

  assign unpack_vec = apply_slot(ref_q, unpack_src, unpack_slot);
  assign cur_empty  = slot_empty(unpack_src, unpack_slot);
  assign next_empty = slot_empty(unpack_src, unpack_slot + 1);

  // Next-state logic: restart wins, then the per-state entry handling.
  // Looking one slot ahead lets an entry with k filled slots free the input after k cycles.
  always_comb begin
    state_d      = state_q;
    out_valid_d  = out_valid_q && !out_ready;
    out_vector_d = out_vector_q;
    ref_d        = ref_q;
    ref_valid_d  = ref_valid_q;
    entry_d      = entry_q;
    slot_d       = slot_q;
    err_d        = err_q;
    cnt_d        = cnt_q + 32'(handoff);

    if (restart) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
      ref_valid_d = 1'b0;
      slot_d      = '0;
      cnt_d       = cnt_q;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (in_comp != COMPRESSED) begin
              ref_d        = in_vector;
              ref_valid_d  = 1'b1;
              out_vector_d = in_vector;
              out_valid_d  = 1'b1;
              state_d      = EMIT;
            end else if (!ref_valid_q) begin
              err_d = 1'b1;
            end else if (!cur_empty) begin
              ref_d        = unpack_vec;
              out_vector_d = unpack_vec;
              out_valid_d  = 1'b1;
              entry_d      = in_vector;
              if (!next_empty) begin
                slot_d  = SW'(1);
                state_d = UNPACK;
              end
            end
          end
        end
        UNPACK: begin
          if (cur_empty) begin
            slot_d  = '0;
            state_d = IDLE;
          end else if (out_free) begin
            ref_d        = unpack_vec;
            out_vector_d = unpack_vec;
            out_valid_d  = 1'b1;
            if (next_empty) begin
              slot_d  = '0;
              state_d = IDLE;
            end else begin
              slot_d = slot_q + SW'(1);
            end
          end
        end
        EMIT: begin
          if (handoff) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      out_valid_q  <= 1'b0;
      out_vector_q <= '0;
      ref_q        <= '0;
      ref_valid_q  <= 1'b0;
      entry_q      <= '0;
      slot_q       <= '0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      out_valid_q  <= out_valid_d;
      out_vector_q <= out_vector_d;
      ref_q        <= ref_d;
      ref_valid_q  <= ref_valid_d;
      entry_q      <= entry_d;
      slot_q       <= slot_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_vector  = out_vector_q;
  assign err_no_base = err_q;
  assign vec_count   = cnt_q;

endmodule

// File: tb/tb_delta_decompressor.sv
// tb_delta_decompressor
// Directed scenarios for pass-through, delta unpacking, back-pressure, restart and
// reset, followed by a randomized stream checked against a queue-based model.
module tb_delta_decompressor;

  localparam int NL   = 2;
  localparam int DW   = 32;
  localparam int NENT = 60;

  logic            clk;
  logic            rst_n;
  logic            restart;
  logic            in_valid;
  logic            in_ready;
  logic [NL*DW-1:0] in_vector;
  logic            in_comp;
  logic            out_valid;
  logic            out_ready;
  logic [NL*DW-1:0] out_vector;
  logic            err_no_base;
  logic [31:0]     vec_count;

  int tests_run = 0;
  int tests_failed = 0;

  logic [31:0] m_ref [NL];
  logic        m_ref_valid;
  logic        m_err;
  int          m_count;
  logic [63:0] exp_q [$];

  delta_decompressor #(
    .N(NL),
    .DATA_WIDTH(DW),
    .DELTA_SLOTS(4),
    .COMPRESSED(1'b0)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .restart(restart),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_vector(in_vector),
    .in_comp(in_comp),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_vector(out_vector),
    .err_no_base(err_no_base),
    .vec_count(vec_count)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] vec2(input logic [31:0] lane0, input logic [31:0] lane1);
    return {lane1, lane0};
  endfunction

  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic comp, input logic [63:0] vec);
    in_valid  = valid;
    in_comp   = comp;
    in_vector = vec;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    assert (got === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: apply an accepted entry using plain signed arithmetic.
  task automatic modelEntry(input logic comp, input logic [63:0] v);
    logic [7:0] b;
    int         d;
    if (comp != 1'b0) begin
      m_ref[0]    = v[31:0];
      m_ref[1]    = v[63:32];
      m_ref_valid = 1'b1;
      exp_q.push_back(v);
    end else if (!m_ref_valid) begin
      m_err = 1'b1;
    end else begin
      for (int s = 0; s < 4; s++) begin
        b = 8'(v[31:0] >> (24 - 8*s));
        if (b == 8'h80) break;
        for (int l = 0; l < NL; l++) begin
          d = int'($signed(8'(v[l*32 +: 32] >> (24 - 8*s))));
          m_ref[l] = m_ref[l] - 32'(d);
        end
        exp_q.push_back({m_ref[1], m_ref[0]});
      end
    end
  endtask

  task automatic newEntry(output logic [63:0] v, output logic comp);
    logic [7:0] b;
    comp = ($urandom_range(0, 3) == 0);
    v    = {$urandom(), $urandom()};
    if (!comp) begin
      for (int s = 0; s < 4; s++) begin
        b = 8'($urandom());
        if ($urandom_range(0, 3) == 0) b = 8'h80;
        v[31 - 8*s -: 8] = b;
      end
    end
  endtask

  // Directed steps followed by the randomized stream.
  initial begin
    logic [63:0] cur;
    logic        cur_comp;
    logic [63:0] got;
    logic [63:0] expv;
    logic        acc;
    logic        hs;
    int          sent;

    rst_n = 1'b0;
    restart = 1'b0;
    out_ready = 1'b1;
    applyStimulus(1'b0, 1'b0, 64'h0);
    #2;
    checkOutput("rst_in_ready", 64'(in_ready), 64'(0));
    checkOutput("rst_out_valid", 64'(out_valid), 64'(0));
    checkOutput("rst_out_vector", out_vector, 64'h0);
    checkOutput("rst_err", 64'(err_no_base), 64'(0));
    checkOutput("rst_count", 64'(vec_count), 64'(0));
    stepClock();
    stepClock();
    rst_n = 1'b1;
    #1;
    checkOutput("idle_in_ready", 64'(in_ready), 64'(1));

    // Uncompressed pass-through
    applyStimulus(1'b1, 1'b1, vec2(100, 5));
    #1;
    checkOutput("t1_accept", 64'(in_ready), 64'(1));
    stepClock();
    applyStimulus(1'b0, 1'b0, 64'h0);
    #1;
    checkOutput("t1_valid", 64'(out_valid), 64'(1));
    checkOutput("t1_vector", out_vector, vec2(100, 5));
    checkOutput("t1_busy", 64'(in_ready), 64'(0));
    stepClock();
    #1;
    checkOutput("t1_ready_again", 64'(in_ready), 64'(1));
    checkOutput("t1_count", 64'(vec_count), 64'(1));
    checkOutput("t1_drained", 64'(out_valid), 64'(0));

    // Compressed entry with three filled slots
    applyStimulus(1'b1, 1'b0, {32'hFFFE0180, 32'h01020380});
    #1;
    checkOutput("t2_accept", 64'(in_ready), 64'(1));
    stepClock();
    applyStimulus(1'b0, 1'b0, 64'h0);
    #1;
    checkOutput("t2_v0_valid", 64'(out_valid), 64'(1));
    checkOutput("t2_v0", out_vector, vec2(99, 6));
    checkOutput("t2_v0_busy", 64'(in_ready), 64'(0));
    stepClock();
    #1;
    checkOutput("t2_v1", out_vector, vec2(97, 8));
    checkOutput("t2_v1_busy", 64'(in_ready), 64'(0));
    stepClock();
    #1;
    checkOutput("t2_v2_valid", 64'(out_valid), 64'(1));
    checkOutput("t2_v2", out_vector, vec2(94, 7));
    checkOutput("t2_v2_free", 64'(in_ready), 64'(1));
    stepClock();
    #1;
    checkOutput("t2_done_valid", 64'(out_valid), 64'(0));
    checkOutput("t2_count", 64'(vec_count), 64'(4));

    // Compressed entry whose first slot is empty
    applyStimulus(1'b1, 1'b0, {32'h12345678, 32'h80808080});
    #1;
    checkOutput("t3_accept", 64'(in_ready), 64'(1));
    stepClock();
    applyStimulus(1'b0, 1'b0, 64'h0);
    #1;
    checkOutput("t3_no_output", 64'(out_valid), 64'(0));
    checkOutput("t3_ready", 64'(in_ready), 64'(1));
    checkOutput("t3_err_clear", 64'(err_no_base), 64'(0));
    applyStimulus(1'b1, 1'b0, {32'h00000000, 32'h04808080});
    stepClock();
    applyStimulus(1'b0, 1'b0, 64'h0);
    #1;
    checkOutput("t3_ref_kept", out_vector, vec2(90, 7));
    stepClock();
    #1;
    checkOutput("t3_count", 64'(vec_count), 64'(5));

    // Back-pressure on the second unpacked vector
    applyStimulus(1'b1, 1'b1, vec2(100, 5));
    stepClock();
    applyStimulus(1'b0, 1'b0, 64'h0);
    stepClock();
    applyStimulus(1'b1, 1'b0, {32'hFFFE0180, 32'h01020380});
    stepClock();
    applyStimulus(1'b0, 1'b0, 64'h0);
    #1;
    checkOutput("t5_v0", out_vector, vec2(99, 6));
    stepClock();
    out_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      checkOutput("t5_hold_vec", out_vector, vec2(97, 8));
      checkOutput("t5_hold_valid", 64'(out_valid), 64'(1));
      checkOutput("t5_hold_busy", 64'(in_ready), 64'(0));
      stepClock();
    end
    out_ready = 1'b1;
    #1;
    checkOutput("t5_release_vec", out_vector, vec2(97, 8));
    stepClock();
    #1;
    checkOutput("t5_v2", out_vector, vec2(94, 7));
    stepClock();
    #1;
    checkOutput("t5_done_valid", 64'(out_valid), 64'(0));
    checkOutput("t5_count", 64'(vec_count), 64'(9));

    // Restart during the second slot
    applyStimulus(1'b1, 1'b1, vec2(100, 5));
    stepClock();
    applyStimulus(1'b0, 1'b0, 64'h0);
    stepClock();
    applyStimulus(1'b1, 1'b0, {32'hFFFE0180, 32'h01020380});
    stepClock();
    applyStimulus(1'b0, 1'b0, 64'h0);
    stepClock();
    #1;
    checkOutput("t6_v1", out_vector, vec2(97, 8));
    restart = 1'b1;
    out_ready = 1'b0;
    applyStimulus(1'b1, 1'b0, {32'h00000000, 32'h01808080});
    #1;
    checkOutput("t6_restart_block", 64'(in_ready), 64'(0));
    stepClock();
    restart = 1'b0;
    out_ready = 1'b1;
    applyStimulus(1'b0, 1'b0, 64'h0);
    #1;
    checkOutput("t6_valid_cleared", 64'(out_valid), 64'(0));
    checkOutput("t6_count_held", 64'(vec_count), 64'(11));
    checkOutput("t6_ready", 64'(in_ready), 64'(1));
    applyStimulus(1'b1, 1'b0, {32'h11223344, 32'h01020304});
    stepClock();
    applyStimulus(1'b0, 1'b0, 64'h0);
    #1;
    checkOutput("t6_err", 64'(err_no_base), 64'(1));
    checkOutput("t6_no_output", 64'(out_valid), 64'(0));

    // Asynchronous reset in the middle of an entry
    applyStimulus(1'b1, 1'b1, vec2(100, 5));
    stepClock();
    applyStimulus(1'b0, 1'b0, 64'h0);
    stepClock();
    applyStimulus(1'b1, 1'b0, {32'hFFFE0180, 32'h01020380});
    stepClock();
    applyStimulus(1'b0, 1'b0, 64'h0);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("ar_valid", 64'(out_valid), 64'(0));
    checkOutput("ar_vector", out_vector, 64'h0);
    checkOutput("ar_count", 64'(vec_count), 64'(0));
    checkOutput("ar_err", 64'(err_no_base), 64'(0));
    checkOutput("ar_in_ready", 64'(in_ready), 64'(0));
    stepClock();
    rst_n = 1'b1;
    #1;

    // Compressed entry with no reference after reset
    applyStimulus(1'b1, 1'b0, {32'hFFFE0180, 32'h01020380});
    #1;
    checkOutput("t4_accept", 64'(in_ready), 64'(1));
    stepClock();
    applyStimulus(1'b0, 1'b0, 64'h0);
    #1;
    checkOutput("t4_err", 64'(err_no_base), 64'(1));
    checkOutput("t4_no_output", 64'(out_valid), 64'(0));
    checkOutput("t4_ready", 64'(in_ready), 64'(1));
    stepClock();
    #1;
    checkOutput("t4_still_idle", 64'(out_valid), 64'(0));

    // Randomized stream against the model
    m_ref[0] = '0;
    m_ref[1] = '0;
    m_ref_valid = 1'b0;
    m_err = 1'b1;
    m_count = 0;
    sent = 0;
    newEntry(cur, cur_comp);
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (sent >= NENT && exp_q.size() == 0) break;
      out_ready = ($urandom_range(0, 3) != 0);
      applyStimulus(sent < NENT, cur_comp, cur);
      #1;
      acc = in_valid && in_ready;
      hs  = out_valid && out_ready;
      got = out_vector;
      stepClock();
      if (hs) begin
        checkOutput("rand_avail", 64'(exp_q.size() != 0), 64'(1));
        if (exp_q.size() != 0) begin
          expv = exp_q.pop_front();
          checkOutput("rand_vec", got, expv);
          m_count++;
        end
      end
      if (acc) begin
        modelEntry(cur_comp, cur);
        sent++;
        newEntry(cur, cur_comp);
      end
    end
    applyStimulus(1'b0, 1'b0, 64'h0);
    out_ready = 1'b1;
    #1;
    checkOutput("rand_sent", 64'(sent), 64'(NENT));
    checkOutput("rand_drain", 64'(exp_q.size()), 64'(0));
    checkOutput("rand_count", 64'(vec_count), 64'(m_count));
    checkOutput("rand_err", 64'(err_no_base), 64'(m_err));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
